// File: rtl/raster_pixel_packer.sv
// Thresholds evaluator samples into 1-bit pixels, packs them LSB-first into words, queues them in a FWFT FIFO.
// Optional per-frame inside-pixel counter enabled by macro PIXEL_PACKER_STATS_EN.
module raster_pixel_packer #(
  parameter int WIDTH      = 64,
  parameter int PACK_W     = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int AF_MARGIN  = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  input  logic [WIDTH-1:0]  in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PACK_W-1:0] out_data,
  output logic              out_last,
  output logic              almost_full,
  output logic              overflow,
  output logic              frame_done,
  output logic [31:0]       inside_count
);

  localparam int IW = $clog2(PACK_W);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [IW-1:0] IDX_MAX = IW'(PACK_W - 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_MARGIN);

  logic [IW-1:0]         r_idx;
  logic [PACK_W-1:0]     r_pack;
  logic [PACK_W-1:0]     r_mem [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] r_mem_last;
  logic [AW-1:0]         r_wptr;
  logic [AW-1:0]         r_rptr;
  logic [CW-1:0]         r_cnt;

  logic              w_pix;
  logic              w_done;
  logic [PACK_W-1:0] w_word;
  logic              w_empty;
  logic              w_full;
  logic              w_pop;
  logic              w_push;
  logic [CW-1:0]     w_cnt_nxt;
  logic [CW-1:0]     w_free;
  logic              w_unused;

  assign w_pix     = in_data[WIDTH-1];
  assign w_unused  = ^in_data[WIDTH-2:0];
  assign w_done    = in_valid && (in_last || (r_idx == IDX_MAX));
  assign w_word    = r_pack | (PACK_W'(w_pix) << r_idx);
  assign w_empty   = (r_cnt == '0);
  assign w_full    = (r_cnt == DEPTH_C);
  assign w_pop     = !w_empty && out_ready;
  // A pop frees the head slot at the same edge, so a full FIFO can still take a push.
  assign w_push    = w_done && (!w_full || w_pop);
  assign w_cnt_nxt = r_cnt + CW'(w_push) - CW'(w_pop);
  assign w_free    = DEPTH_C - w_cnt_nxt;

  assign out_valid = !w_empty;
  assign out_data  = w_empty ? '0 : r_mem[r_rptr];
  assign out_last  = !w_empty && r_mem_last[r_rptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_idx  <= '0;
      r_pack <= '0;
    end else if (in_valid) begin
      if (w_done) begin
        r_idx  <= '0;
        r_pack <= '0;
      end else begin
        r_idx  <= r_idx + IW'(1);
        r_pack <= w_word;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr]      <= w_word;
      r_mem_last[r_wptr] <= in_last;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_cnt       <= '0;
      almost_full <= 1'b0;
      overflow    <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      r_cnt       <= w_cnt_nxt;
      almost_full <= (w_free <= AF_C);
      frame_done  <= w_pop && r_mem_last[r_rptr];
      if (w_done && !w_push) overflow <= 1'b1;
    end
  end

`ifdef PIXEL_PACKER_STATS_EN
  logic [31:0] r_stat;
  logic [31:0] r_inside;
  logic [31:0] w_sum;

  assign w_sum        = (r_stat == 32'hFFFF_FFFF) ? r_stat : r_stat + {31'b0, w_pix};
  assign inside_count = r_inside;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stat   <= '0;
      r_inside <= '0;
    end else if (in_valid) begin
      if (in_last) begin
        r_stat   <= '0;
        r_inside <= w_sum;
      end else begin
        r_stat   <= w_sum;
      end
    end
  end
`else
  assign inside_count = '0;
`endif

endmodule

// File: tb/tb_raster_pixel_packer.sv
// Randomized and directed bench for raster_pixel_packer against a queue-based reference model.
module tb_raster_pixel_packer;
  localparam int WIDTH = 64;
  localparam int PACK_W = 32;
  localparam int DEPTH = 8;
  localparam int AFM = 3;

  logic              clk;
  logic              reset_n;
  logic              in_valid;
  logic [WIDTH-1:0]  in_data;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [PACK_W-1:0] out_data;
  logic              out_last;
  logic              almost_full;
  logic              overflow;
  logic              frame_done;
  logic [31:0]       inside_count;

  raster_pixel_packer #(.WIDTH(WIDTH), .PACK_W(PACK_W), .FIFO_DEPTH(DEPTH), .AF_MARGIN(AFM)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .almost_full(almost_full), .overflow(overflow), .frame_done(frame_done),
    .inside_count(inside_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int errors = 0;
  int checks = 0;

  // Reference model: words as {last, data}, pixels accumulated arithmetically.
  logic [32:0] m_q[$];
  int          m_n;
  logic [31:0] m_word;
  bit          m_ov, m_af, m_fd;
  longint      m_stat;
  logic [31:0] m_inside;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_n = 0; m_word = 0; m_ov = 0; m_af = 0; m_fd = 0; m_stat = 0; m_inside = 0;
  endtask

  task automatic model_step();
    bit p;
    bit pop;
    pop  = (m_q.size() > 0) && out_ready;
    m_fd = pop && m_q[0][32];
    if (pop) void'(m_q.pop_front());
    if (in_valid) begin
      p = in_data[WIDTH-1];
      if (p) m_word = m_word | (32'd1 << m_n);
      if (m_stat < 64'hFFFF_FFFF) m_stat = m_stat + p;
      if (in_last) begin
        m_inside = m_stat[31:0];
        m_stat = 0;
      end
      if (m_n == PACK_W - 1 || in_last) begin
        if (m_q.size() < DEPTH) m_q.push_back({in_last, m_word});
        else m_ov = 1;
        m_word = 0;
        m_n = 0;
      end else begin
        m_n++;
      end
    end
    m_af = (DEPTH - m_q.size()) <= AFM;
  endtask

  task automatic compare();
    logic [31:0] exp_ic;
`ifdef PIXEL_PACKER_STATS_EN
    exp_ic = m_inside;
`else
    exp_ic = 32'd0;
`endif
    chk("out_valid", out_valid, m_q.size() > 0);
    if (m_q.size() > 0) begin
      chk("out_data", out_data, m_q[0][31:0]);
      chk("out_last", out_last, m_q[0][32]);
    end
    chk("almost_full", almost_full, m_af);
    chk("overflow", overflow, m_ov);
    chk("frame_done", frame_done, m_fd);
    chk("inside_count", inside_count, exp_ic);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    compare();
  endtask

  task automatic send(input bit p, input bit last);
    in_valid = 1'b1;
    in_last  = last;
    in_data  = {p, $urandom(), 31'($urandom())};
    cycle();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int k = 0; k < 40 && m_q.size() > 0; k++) cycle();
    cycle();
    chk("drain_empty", out_valid, 1'b0);
  endtask

  task automatic check_reset_vals(input string nm);
    chk({nm, "_valid"}, out_valid, 1'b0);
    chk({nm, "_data"}, out_data, 32'd0);
    chk({nm, "_last"}, out_last, 1'b0);
    chk({nm, "_af"}, almost_full, 1'b0);
    chk({nm, "_ov"}, overflow, 1'b0);
    chk({nm, "_fd"}, frame_done, 1'b0);
    chk({nm, "_ic"}, inside_count, 32'd0);
  endtask

  task automatic do_reset();
    in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_reset_vals("rst_async");
    @(posedge clk);
    #1;
    check_reset_vals("rst_hold");
    reset_n = 1'b1;
  endtask

  logic [31:0] exp_ic6;

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
    model_reset();
    #2;
    check_reset_vals("init");
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // 1) alternating pixels, last on 32nd
    for (int j = 0; j < 32; j++) send((j % 2) == 0, j == 31);
    chk("t1_data", out_data, 32'h5555_5555);
    chk("t1_last", out_last, 1'b1);
    out_ready = 1'b1;
    cycle();
    chk("t1_fd", frame_done, 1'b1);
    out_ready = 1'b0;
    cycle();
    chk("t1_fd_low", frame_done, 1'b0);

    // 2) short frame of 5, then next frame restarts at bit 0
    for (int j = 0; j < 5; j++) send(1'b1, j == 4);
    chk("t2_data", out_data, 32'h0000_001F);
    chk("t2_last", out_last, 1'b1);
    send(1'b1, 1'b1);
    chk("t2_model_next", m_q[1][31:0], 32'h0000_0001);
    drain();

    // 3) nine full words into the stalled FIFO
    out_ready = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      for (int j = 0; j < 32; j++) send(((j * 7 + k * 3) % 5) < 2, 1'b0);
      if (k == 4) chk("t3_af_at4", almost_full, 1'b0);
      if (k == 5) chk("t3_af_at5", almost_full, 1'b1);
    end
    chk("t3_overflow", overflow, 1'b1);
    chk("t3_kept", m_q.size(), 8);
    drain();

    // 4) full FIFO with a pop on the completing cycle of word 9
    do_reset();
    for (int k = 1; k <= 9; k++) begin
      for (int j = 0; j < 32; j++) begin
        out_ready = (k == 9) && (j == 31);
        send(((j + k) % 3) == 0, 1'b0);
      end
    end
    out_ready = 1'b0;
    chk("t4_no_overflow", overflow, 1'b0);
    chk("t4_held", m_q.size(), 8);
    drain();

    // 5) reset mid-frame with a word queued
    for (int j = 0; j < 32; j++) send(1'b1, 1'b0);
    for (int j = 0; j < 10; j++) send(1'b1, 1'b0);
    do_reset();
    for (int j = 0; j < 32; j++) send(j < 3, 1'b0);
    chk("t5_data", out_data, 32'h0000_0007);
    chk("t5_last", out_last, 1'b0);
    drain();

    // 6) 64-pixel frame with 20 inside pixels
    for (int j = 0; j < 64; j++) send((j < 60) && ((j % 3) == 0), j == 63);
`ifdef PIXEL_PACKER_STATS_EN
    exp_ic6 = 32'd20;
`else
    exp_ic6 = 32'd0;
`endif
    chk("t6_inside", inside_count, exp_ic6);
    drain();

    // Random traffic
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) != 0) begin
        in_valid = 1'b1;
        in_last  = ($urandom_range(0, 39) == 0);
        in_data  = {$urandom(), $urandom()};
      end else begin
        in_valid = 1'b0;
        in_last  = 1'b0;
      end
      cycle();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
